uart_word_bridge: RTL and testbench

// Width adapter between the core's 32-bit UART port and a byte-wide UART link.
// TX path: takes one 32-bit word from the core, sends it as BYTES_PER_WORD bytes, LSB first.
// RX path: gathers received bytes, emitted one at a time with the UART's write-back strobe, back into 32-bit words.

---
 rtl/uart_word_bridge.sv | 169 ++++++++++++++++
 tb/tb_uart_word_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_bridge.sv
// uart_word_bridge
// Width adapter between a 32-bit core UART port and a byte-wide UART link.
//   TX: accepts one 32-bit word and sends it as four bytes, LSB first.
//   RX: gathers received bytes back into 32-bit words. A partial word is
//       dropped if the link stays idle too long between bytes.
// The two paths are independent and may both be active on the same cycle.
//
// Ports
//   clock, reset       system clock; synchronous active-high reset
//   word_valid/word_in core word offered for transmission
//   word_ready         TX path idle, a word can be accepted
//   tx_byte/tx_start   byte and one-cycle latch strobe to the UART transmitter
//   tx_done            one-cycle pulse from the UART: byte sent
//   tx_word_done       one-cycle pulse: last byte of the word has been sent
//   rx_flag/rx_byte    one-cycle strobe and byte from the UART receiver
//   rx_word_valid      one-cycle pulse: rx_word was just updated
//   rx_word            last complete word, held until the next one completes
//   rx_timeout         one-cycle pulse: a partial word was dropped
//   busy               TX path active or RX holding a partial word
//
// state   | meaning
// TX_IDLE | waiting for a word from the core
// TX_SEND | presenting the current byte with tx_start
// TX_WAIT | byte handed to UART, waiting for tx_done
module uart_word_bridge #(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        word_valid,
  input  logic [31:0] word_in,
  output logic        word_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        tx_word_done,
  input  logic        rx_flag,
  input  logic [7:0]  rx_byte,
  output logic        rx_word_valid,
  output logic [31:0] rx_word,
  output logic        rx_timeout,
  output logic        busy
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  // One spare count of headroom so the timer can reach TIMEOUT_CYCLES.
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [31:0]      tx_shift_q, tx_shift_d;
  logic [IDX_W-1:0] tx_idx_q, tx_idx_d;
  logic             tx_word_done_q, tx_word_done_d;
  logic             word_ready_q, word_ready_d;

  logic [IDX_W-1:0] rx_idx_q, rx_idx_d;
  logic [31:0]      rx_acc_q, rx_acc_d;
  logic [31:0]      rx_word_q, rx_word_d;
  logic             rx_word_valid_q, rx_word_valid_d;
  logic             rx_timeout_q, rx_timeout_d;
  logic [TMR_W-1:0] rx_timer_q, rx_timer_d;

  always_comb begin
    tx_state_d     = tx_state_q;
    tx_shift_d     = tx_shift_q;
    tx_idx_d       = tx_idx_q;
    tx_word_done_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (word_valid && word_ready_q) begin
          tx_shift_d = word_in;
          tx_idx_d   = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: tx_state_d = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) begin
          if (tx_idx_q == LAST_IDX) begin
            tx_word_done_d = 1'b1;
            tx_state_d     = TX_IDLE;
          end else begin
            tx_shift_d = {8'h00, tx_shift_q[31:8]};
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_state_d = TX_SEND;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Registered so it reads 0 during reset and rises together with TX_IDLE.
    word_ready_d = (tx_state_d == TX_IDLE);
  end

  always_comb begin
    rx_idx_d        = rx_idx_q;
    rx_acc_d        = rx_acc_q;
    rx_word_d       = rx_word_q;
    rx_word_valid_d = 1'b0;
    rx_timeout_d    = 1'b0;
    rx_timer_d      = rx_timer_q;
    // A byte always wins over a timer expiring on the same cycle.
    if (rx_flag) begin
      rx_acc_d[8*int'(rx_idx_q) +: 8] = rx_byte;
      rx_timer_d = '0;
      if (rx_idx_q == LAST_IDX) begin
        rx_word_d       = rx_acc_d;
        rx_word_valid_d = 1'b1;
        rx_idx_d        = '0;
      end else begin
        rx_idx_d = rx_idx_q + 1'b1;
      end
    end else if (rx_idx_q != '0) begin
      if (rx_timer_q == TMR_LAST) begin
        rx_idx_d     = '0;
        rx_timer_d   = '0;
        rx_timeout_d = 1'b1;
      end else begin
        rx_timer_d = rx_timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q      <= TX_IDLE;
      tx_shift_q      <= '0;
      tx_idx_q        <= '0;
      tx_word_done_q  <= 1'b0;
      word_ready_q    <= 1'b0;
      rx_idx_q        <= '0;
      rx_acc_q        <= '0;
      rx_word_q       <= '0;
      rx_word_valid_q <= 1'b0;
      rx_timeout_q    <= 1'b0;
      rx_timer_q      <= '0;
    end else begin
      tx_state_q      <= tx_state_d;
      tx_shift_q      <= tx_shift_d;
      tx_idx_q        <= tx_idx_d;
      tx_word_done_q  <= tx_word_done_d;
      word_ready_q    <= word_ready_d;
      rx_idx_q        <= rx_idx_d;
      rx_acc_q        <= rx_acc_d;
      rx_word_q       <= rx_word_d;
      rx_word_valid_q <= rx_word_valid_d;
      rx_timeout_q    <= rx_timeout_d;
      rx_timer_q      <= rx_timer_d;
    end
  end

  assign word_ready    = word_ready_q;
  assign tx_byte       = tx_shift_q[7:0];
  assign tx_start      = (tx_state_q == TX_SEND);
  assign tx_word_done  = tx_word_done_q;
  assign rx_word_valid = rx_word_valid_q;
  assign rx_word       = rx_word_q;
  assign rx_timeout    = rx_timeout_q;
  assign busy          = (tx_state_q != TX_IDLE) || (rx_idx_q != '0);

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge. A small UART model answers each
// tx_start with tx_done three cycles later and logs the bytes sent.
module tb_uart_word_bridge;

  localparam int TMO = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        word_valid;
  logic [31:0] word_in;
  logic        word_ready;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_done;
  logic        tx_word_done;
  logic        rx_flag;
  logic [7:0]  rx_byte;
  logic        rx_word_valid;
  logic [31:0] rx_word;
  logic        rx_timeout;
  logic        busy;

  uart_word_bridge #(.BYTES_PER_WORD(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .word_valid(word_valid), .word_in(word_in), .word_ready(word_ready),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_done(tx_done),
    .tx_word_done(tx_word_done),
    .rx_flag(rx_flag), .rx_byte(rx_byte), .rx_word_valid(rx_word_valid),
    .rx_word(rx_word), .rx_timeout(rx_timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0, n_wdone = 0, n_rxv = 0, n_to = 0;
  int done_cnt = 0;
  bit resp_en = 1'b1;
  logic [7:0] tx_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // UART model and pulse counters, sampled 1 time unit after each rising edge.
  always begin
    @(posedge clock);
    #1;
    tx_done = 1'b0;
    if (!resp_en) begin
      done_cnt = 0;
    end else if (tx_start) begin
      tx_q.push_back(tx_byte);
      n_start++;
      done_cnt = 3;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) tx_done = 1'b1;
    end
    if (tx_word_done)  n_wdone++;
    if (rx_word_valid) n_rxv++;
    if (rx_timeout)    n_to++;
  end

  task automatic wait_wdone(input string tag, input int target);
    int i = 0;
    while (n_wdone < target && i < 300) begin
      @(negedge clock);
      i++;
    end
    chk(tag, n_wdone, target);
  endtask

  task automatic rx_send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clock);
    rx_flag = 1'b1;
    rx_byte = b;
    @(negedge clock);
    rx_flag = 1'b0;
  endtask

  task automatic chk_tx(input string tag, input logic [31:0] w, input int off);
    logic [7:0] got;
    for (int i = 0; i < 4; i++) begin
      got = (off + i < tx_q.size()) ? tx_q[off + i] : 8'hxx;
      chk(tag, {24'h0, got}, {24'h0, w[8*i +: 8]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_start, b_wdone, b_rxv, b_to;
    reset = 1'b1; word_valid = 1'b0; word_in = '0; tx_done = 1'b0;
    rx_flag = 1'b0; rx_byte = '0;
    repeat (2) @(negedge clock);
    chk("reset_outs", {word_ready, tx_byte, tx_start, tx_word_done, rx_word_valid,
                       rx_timeout, busy}, 32'h0);
    chk("reset_rx_word", rx_word, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", {31'h0, word_ready}, 32'h1);

    // 1: single word
    word_valid = 1'b1; word_in = 32'hA1B2C3D4;
    @(negedge clock);
    word_valid = 1'b0;
    chk("t1_ready_low", {31'h0, word_ready}, 32'h0);
    chk("t1_start_pulse", {31'h0, tx_start}, 32'h1);
    wait_wdone("t1_wdone", 1);
    chk("t1_ready_back", {31'h0, word_ready}, 32'h1);
    chk("t1_nstart", n_start, 4);
    chk("t1_nbytes", tx_q.size(), 4);
    chk_tx("t1_byte", 32'hA1B2C3D4, 0);
    repeat (5) @(negedge clock);
    chk("t1_wdone_once", n_wdone, 1);

    // 2: RX word at varied spacing
    rx_send(8'h78, 0); rx_send(8'h56, 5); rx_send(8'h34, 2); rx_send(8'h12, 10);
    chk("t2_valid_pulse", {31'h0, rx_word_valid}, 32'h1);
    chk("t2_rx_word", rx_word, 32'h12345678);
    repeat (5) @(negedge clock);
    chk("t2_rxv_once", n_rxv, 1);

    // 3: partial word dropped on timeout, then a clean word
    rx_send(8'h11, 0); rx_send(8'h22, 3);
    chk("t3_busy_partial", {31'h0, busy}, 32'h1);
    repeat (TMO + 5) @(negedge clock);
    chk("t3_timeout", n_to, 1);
    chk("t3_word_kept", rx_word, 32'h12345678);
    chk("t3_busy_clear", {31'h0, busy}, 32'h0);
    rx_send(8'h01, 0); rx_send(8'h02, 0); rx_send(8'h03, 0); rx_send(8'h04, 0);
    chk("t3_rx_word", rx_word, 32'h04030201);
    // Bytes landing exactly on the expiry cycle are accepted.
    rx_send(8'hAA, 0); rx_send(8'hBB, TMO - 1); rx_send(8'hCC, TMO - 1);
    rx_send(8'hDD, TMO - 1);
    chk("t3_edge_word", rx_word, 32'hDDCCBBAA);
    chk("t3_edge_no_to", n_to, 1);
    chk("t3_rxv_count", n_rxv, 3);

    // 4: second word held while TX is busy
    tx_q.delete();
    b_start = n_start;
    word_valid = 1'b1; word_in = 32'h11223344;
    @(negedge clock);
    word_in = 32'h55667788;
    wait_wdone("t4_wdone1", 2);
    chk("t4_no_early_start", n_start - b_start, 4);
    chk("t4_ready_idle", {31'h0, word_ready}, 32'h1);
    @(negedge clock);
    word_valid = 1'b0;
    chk("t4_accept_start", {31'h0, tx_start}, 32'h1);
    chk("t4_accept_ready", {31'h0, word_ready}, 32'h0);
    wait_wdone("t4_wdone2", 3);
    chk("t4_nbytes", tx_q.size(), 8);
    chk_tx("t4_w1", 32'h11223344, 0);
    chk_tx("t4_w2", 32'h55667788, 4);

    // 5: full duplex
    tx_q.delete();
    b_rxv = n_rxv;
    fork
      begin
        word_valid = 1'b1; word_in = 32'hDEADBEEF;
        @(negedge clock);
        word_valid = 1'b0;
        wait_wdone("t5_wdone", 4);
      end
      begin
        rx_send(8'h0D, 1); rx_send(8'hF0, 3); rx_send(8'hFE, 0); rx_send(8'hCA, 7);
      end
    join
    chk_tx("t5_tx", 32'hDEADBEEF, 0);
    chk("t5_rx_word", rx_word, 32'hCAFEF00D);
    chk("t5_rxv", n_rxv - b_rxv, 1);

    // 6: reset mid-operation on both paths
    rx_send(8'h99, 0); rx_send(8'h88, 0);
    b_start = n_start;
    word_valid = 1'b1; word_in = 32'h01020304;
    @(negedge clock);
    word_valid = 1'b0;
    begin
      int i = 0;
      while (n_start < b_start + 2 && i < 100) begin
        @(negedge clock);
        i++;
      end
    end
    chk("t6_two_starts", n_start - b_start, 2);
    reset = 1'b1; resp_en = 1'b0;
    @(negedge clock);
    chk("t6_outs_zero", {word_ready, tx_byte, tx_start, tx_word_done, rx_word_valid,
                         rx_timeout, busy}, 32'h0);
    chk("t6_rx_word_zero", rx_word, 32'h0);
    b_start = n_start; b_wdone = n_wdone; b_rxv = n_rxv; b_to = n_to;
    reset = 1'b0; resp_en = 1'b1;
    repeat (TMO + 20) @(negedge clock);
    chk("t6_no_start", n_start, b_start);
    chk("t6_no_wdone", n_wdone, b_wdone);
    chk("t6_no_rxv", n_rxv, b_rxv);
    chk("t6_no_timeout", n_to, b_to);
    chk("t6_ready", {31'h0, word_ready}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
